// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants: round count, S-box, Rcon and word helpers.
// Optional build macro AES_FWD_EXPAND_EN adds the StExpand state; this package is the same either way.
package aes_pkg;

   localparam int unsigned AES_NR = 10;

   typedef enum logic [1:0] {
      StIdle,
      StExpand,
      StEmit
   } state_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Round constant for round idx (1..10); zero outside that range.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] rc;
      rc = 8'h00;
      case (idx)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One combinational AES-128 key-schedule step: round key r -> round key r-1.
// With AES_FWD_EXPAND_EN it also produces the forward step r-1 -> r through the same S-box row.
module aes_inv_key_step
   import aes_pkg::*;
(
   input  logic [127:0] key,
   input  logic [3:0]   round,
`ifdef AES_FWD_EXPAND_EN
   input  logic         fwd,
   output logic [127:0] next_key,
`endif
   output logic [127:0] prev_key
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] p1, p2, p3;
   logic [31:0] sub_in, mix;

   assign w0 = key[127:96];
   assign w1 = key[95:64];
   assign w2 = key[63:32];
   assign w3 = key[31:0];

   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;

`ifdef AES_FWD_EXPAND_EN
   // Forward expansion feeds the S-box with w3; inverse recovers the previous w3 first.
   assign sub_in = fwd ? w3 : p3;
`else
   assign sub_in = p3;
`endif

   assign mix      = sub_word(rot_word(sub_in)) ^ {rcon(round), 24'h000000};
   assign prev_key = {w0 ^ mix, p1, p2, p3};

`ifdef AES_FWD_EXPAND_EN
   logic [31:0] n0, n1, n2, n3;

   assign n0       = w0 ^ mix;
   assign n1       = w1 ^ n0;
   assign n2       = w2 ^ n1;
   assign n3       = w3 ^ n2;
   assign next_key = {n0, n1, n2, n3};
`endif

endmodule

// File: rtl/aes_inv_key_sched.sv
// Sequential inverse AES-128 key schedule: emits round keys NR..0, one per handshake.
// Define AES_FWD_EXPAND_EN to accept the cipher key and forward-expand it before emitting.
module aes_inv_key_sched
   import aes_pkg::*;
#(
   parameter int unsigned NR    = AES_NR,
   parameter int unsigned IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             ready,
   input  logic [127:0]     key_in,
   output logic             key_valid,
   input  logic             key_ready,
   output logic [127:0]     round_key,
   output logic [IDX_W-1:0] round_idx,
   output logic             last
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NR);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [127:0]     key_q, key_d;
   logic [127:0]     prev_key;
   logic [3:0]       step_round;

   assign step_round = 4'(idx_q);

`ifdef AES_FWD_EXPAND_EN
   logic [127:0] next_key;

   aes_inv_key_step u_step (
      .key      (key_q),
      .round    (step_round),
      .fwd      (state_q == StExpand),
      .next_key (next_key),
      .prev_key (prev_key)
   );
`else
   aes_inv_key_step u_step (
      .key      (key_q),
      .round    (step_round),
      .prev_key (prev_key)
   );
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      key_d   = key_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               key_d = key_in;
`ifdef AES_FWD_EXPAND_EN
               // idx counts the forward round being produced during expansion.
               state_d = StExpand;
               idx_d   = IDX_W'(1);
`else
               state_d = StEmit;
               idx_d   = LastIdx;
`endif
            end
         end
         StExpand: begin
`ifdef AES_FWD_EXPAND_EN
            key_d = next_key;
            if (idx_q == LastIdx) begin
               state_d = StEmit;
            end else begin
               idx_d = idx_q + 1'b1;
            end
`else
            state_d = StIdle;
`endif
         end
         StEmit: begin
            if (key_ready) begin
               if (idx_q == '0) begin
                  state_d = StIdle;
               end else begin
                  key_d = prev_key;
                  idx_d = idx_q - 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         key_q   <= key_d;
      end
   end

   assign ready     = (state_q == StIdle);
   assign key_valid = (state_q == StEmit);
   assign last      = key_valid && (idx_q == '0);
   assign round_key = key_q;
   assign round_idx = idx_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched; honours AES_FWD_EXPAND_EN when defined.
module tb_aes_inv_key_sched;

   localparam int unsigned IDX_W = 4;
`ifdef AES_FWD_EXPAND_EN
   localparam bit             FWD     = 1'b1;
   localparam int             LAT     = 11;
   localparam logic [127:0]   K_FIRST = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
   localparam bit             FWD     = 1'b0;
   localparam int             LAT     = 1;
   localparam logic [127:0]   K_FIRST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif
   localparam logic [127:0] K_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K_R9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] K_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic             clk, rst, start, ready, key_valid, key_ready, last;
   logic [127:0]     key_in, round_key;
   logic [IDX_W-1:0] round_idx;

   aes_inv_key_sched #(.NR(10), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ready     (ready),
      .key_in    (key_in),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .round_key (round_key),
      .round_idx (round_idx),
      .last      (last)
   );

   int            checks, errors;
   logic [7:0]    sbox_t [256];
   int            m_st, m_idx, m_cnt;
   logic [1407:0] m_keys, pin_keys;
   bit            chk_en, rec_en;
   logic [127:0]  beats [11];
   int            nbeats;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      logic       hi;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         hi = aa[7];
         aa = aa << 1;
         if (hi) aa = aa ^ 8'h1b;
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rcon_m(input int r);
      logic [7:0] x;
      x = 8'h01;
      for (int i = 1; i < r; i++) x = gmul(x, 8'h02);
      return x;
   endfunction

   function automatic logic [31:0] f_word(input logic [31:0] w, input int r);
      logic [31:0] rw;
      rw = {w[23:0], w[31:24]};
      return {sbox_t[rw[31:24]], sbox_t[rw[23:16]], sbox_t[rw[15:8]], sbox_t[rw[7:0]]}
             ^ {rcon_m(r), 24'h000000};
   endfunction

   // Whole 44-word schedule from either end; packed so round r sits at [r*128 +: 128].
   function automatic logic [1407:0] keys_of(input logic [127:0] k, input bit from_cipher);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [1407:0] res;
      if (from_cipher) begin
         for (int j = 0; j < 4; j++) w[j] = k[127-32*j -: 32];
         for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = f_word(t, i / 4);
            w[i] = w[i-4] ^ t;
         end
      end else begin
         for (int j = 0; j < 4; j++) w[40+j] = k[127-32*j -: 32];
         for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) t = f_word(t, i / 4);
            w[i-4] = w[i] ^ t;
         end
      end
      for (int r = 0; r < 11; r++)
         for (int j = 0; j < 4; j++) res[r*128 + (3-j)*32 +: 32] = w[4*r+j];
      return res;
   endfunction

   // Protocol model: 0 idle, 1 expanding, 2 emitting.
   always @(posedge clk) begin
      if (rst) begin
         m_st <= 0;
      end else begin
         case (m_st)
            0: if (start) begin
               m_keys <= keys_of(key_in, FWD);
               if (FWD) begin
                  m_st  <= 1;
                  m_cnt <= 10;
               end else begin
                  m_st  <= 2;
                  m_idx <= 10;
               end
            end
            1: if (m_cnt == 1) begin
               m_st  <= 2;
               m_idx <= 10;
            end else begin
               m_cnt <= m_cnt - 1;
            end
            2: if (key_ready) begin
               if (m_idx == 0) m_st <= 0;
               else m_idx <= m_idx - 1;
            end
            default: m_st <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ready", 128'(ready), 128'(m_st == 0));
         check("key_valid", 128'(key_valid), 128'(m_st == 2));
         check("last", 128'(last), 128'(m_st == 2 && m_idx == 0));
         if (m_st == 2) begin
            check("round_key", round_key, m_keys[m_idx*128 +: 128]);
            check("round_idx", 128'(round_idx), 128'(m_idx));
         end
      end
   end

   always @(negedge clk) begin
      if (!rec_en) nbeats <= 0;
      else if (key_valid && key_ready) begin
         if (round_idx < 11) beats[round_idx] <= round_key;
         nbeats <= nbeats + 1;
      end
   end

   task automatic do_start(input logic [127:0] k);
      int lat;
      bit seen;
      start  = 1'b1;
      key_in = k;
      @(posedge clk);
      #1;
      start  = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      lat    = 0;
      seen   = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (key_valid) seen = 1'b1;
         else @(posedge clk);
      end
      check("first_beat_latency", 128'(lat), 128'(LAT));
   endtask

   task automatic wait_done(input bit bp);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk);
         #1;
         if (bp) key_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (key_valid && key_ready && last) done = 1'b1;
      end
      check("final_beat_seen", 128'(done), 128'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until_idx(input int n);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (key_valid && round_idx == IDX_W'(n)) found = 1'b1;
      end
      check("reached_idx", 128'(found), 128'(1));
   endtask

   initial begin
      clk       = 1'b0;
      rst       = 1'b1;
      start     = 1'b0;
      key_ready = 1'b1;
      key_in    = '0;
      checks    = 0;
      errors    = 0;
      chk_en    = 1'b0;
      rec_en    = 1'b0;

      // Reference S-box from GF(2^8) inverse plus affine map.
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv, s;
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_t[x] = s;
      end
      check("model_sbox_00", 128'(sbox_t[8'h00]), 128'(8'h63));
      check("model_sbox_01", 128'(sbox_t[8'h01]), 128'(8'h7c));
      check("model_sbox_53", 128'(sbox_t[8'h53]), 128'(8'hed));
      check("model_rcon_9", 128'(rcon_m(9)), 128'(8'h1b));
      check("model_rcon_10", 128'(rcon_m(10)), 128'(8'h36));
      pin_keys = keys_of(K_R10, 1'b0);
      check("model_inv_r9", pin_keys[9*128 +: 128], K_R9);
      check("model_inv_r0", pin_keys[0 +: 128], K_R0);
      pin_keys = keys_of(K_R0, 1'b1);
      check("model_fwd_r10", pin_keys[10*128 +: 128], K_R10);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ready", 128'(ready), 128'(1));
      check("reset_key_valid", 128'(key_valid), 128'(0));
      check("reset_round_key", round_key, 128'h0);
      check("reset_round_idx", 128'(round_idx), 128'(0));
      check("reset_last", 128'(last), 128'(0));
      @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;

      // FIPS-197 sequence, continuous key_ready, beats recorded.
      rec_en = 1'b1;
      do_start(K_FIRST);
      wait_done(1'b0);
      check("beat_count", 128'(nbeats), 128'(11));
      check("beat_idx10", beats[10], K_R10);
      check("beat_idx9", beats[9], K_R9);
      check("beat_idx1", beats[1], K_R1);
      check("beat_idx0", beats[0], K_R0);
      rec_en = 1'b0;

      // Random backpressure.
      do_start(K_FIRST);
      wait_done(1'b1);
      key_ready = 1'b1;

      // Start while busy must be ignored.
      do_start(K_FIRST);
      wait_until_idx(5);
      start  = 1'b1;
      key_in = 128'h00112233445566778899aabbccddeeff;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1'b0);

      // Reset mid-run, then restart with a new key.
      do_start(K_FIRST);
      wait_until_idx(4);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_key_valid", 128'(key_valid), 128'(0));
      check("midrst_ready", 128'(ready), 128'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_start(128'h000102030405060708090a0b0c0d0e0f);
      wait_done(1'b0);

      // Back-to-back start in the first idle cycle.
      do_start(128'h3c4fcf098815f7aba6d2ae2816157e2b);
      wait_done(1'b0);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
